// File: rtl/aidc_lite_decomp_zrle.sv
// Zero-run-length decompressor: byte-token stream in, one 64-byte block out as 8 words.
// Optional AIDC_LITE_DECOMP_ZRLE_ERRCHK_EN enables format checking and fail_o.
module aidc_lite_decomp_zrle (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        sop_i,
    input  logic        eop_i,
    input  logic [63:0] data_i,
    output logic        valid_o,
    output logic        sop_o,
    output logic        eop_o,
    output logic [2:0]  addr_o,
    output logic [63:0] data_o,
    output logic        done_o,
    output logic        fail_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_ZERO  = 3'd2;
    localparam logic [2:0] S_LIT   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [63:0] hold_q, hold_d;
    logic        full_q, full_d;
    logic [2:0]  ptr_q, ptr_d;
    logic        eop_seen_q, eop_seen_d;
    logic [6:0]  run_q, run_d;
    logic [6:0]  bcnt_q, bcnt_d;
    logic [55:0] asm_q, asm_d;
    logic        vld_q, vld_d;
    logic [2:0]  addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic        done_q, done_d;
`ifdef AIDC_LITE_DECOMP_ZRLE_ERRCHK_EN
    logic        err_q, err_d;
    logic        fail_q, fail_d;
`endif

    logic       xfer, consume, emit;
    logic [7:0] cur_byte, ebyte;
    logic [6:0] len;

    assign xfer     = valid_i & ~full_q;
    assign cur_byte = hold_q[{ptr_q, 3'b000} +: 8];

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        full_d     = full_q;
        ptr_d      = ptr_q;
        eop_seen_d = eop_seen_q;
        run_d      = run_q;
        bcnt_d     = bcnt_q;
        asm_d      = asm_q;
        vld_d      = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;
`ifdef AIDC_LITE_DECOMP_ZRLE_ERRCHK_EN
        err_d      = err_q;
        fail_d     = 1'b0;
`endif
        consume    = 1'b0;
        emit       = 1'b0;
        ebyte      = 8'h00;
        len        = 7'd0;

        case (state_q)
            S_HDR: if (full_q) begin
                consume = 1'b1;
                len     = {1'b0, cur_byte[5:0]} + 7'd1;
`ifdef AIDC_LITE_DECOMP_ZRLE_ERRCHK_EN
                if (cur_byte[6] || (bcnt_q + len > 7'd64)) begin
                    state_d = S_FIN;
                    full_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    run_d   = len;
                    state_d = cur_byte[7] ? S_ZERO : S_LIT;
                end
`else
                run_d   = len;
                state_d = cur_byte[7] ? S_ZERO : S_LIT;
`endif
            end
            S_ZERO: emit = 1'b1;
            S_LIT: if (full_q) begin
                consume = 1'b1;
                emit    = 1'b1;
                ebyte   = cur_byte;
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef AIDC_LITE_DECOMP_ZRLE_ERRCHK_EN
                fail_d  = err_q;
`endif
            end
            default: ;
        endcase

        // Input needed but the eop word is already exhausted: the block is short.
        if ((state_q == S_HDR || state_q == S_LIT) && !full_q && eop_seen_q) begin
`ifdef AIDC_LITE_DECOMP_ZRLE_ERRCHK_EN
            state_d = S_FIN;
            err_d   = 1'b1;
`else
            state_d = S_ZERO;
            run_d   = 7'd64 - bcnt_q;
`endif
        end

        if (xfer && !sop_i) begin
            if (state_q == S_HDR || state_q == S_ZERO || state_q == S_LIT) begin
                hold_d     = data_i;
                full_d     = 1'b1;
                ptr_d      = 3'd0;
                eop_seen_d = eop_seen_q | eop_i;
            end else if (state_q == S_DRAIN && eop_i) begin
                state_d = S_FIN;
            end
        end

        if (consume) begin
            ptr_d = ptr_q + 3'd1;
            if (ptr_q == 3'd7) full_d = 1'b0;
        end

        if (emit) begin
            bcnt_d = bcnt_q + 7'd1;
            asm_d  = {ebyte, asm_q[55:8]};
            run_d  = run_q - 7'd1;
            if (run_q == 7'd1) state_d = S_HDR;
            if (bcnt_q[2:0] == 3'd7) begin
                vld_d  = 1'b1;
                data_d = {ebyte, asm_q};
                addr_d = bcnt_q[5:3];
            end
            // 64th byte: leftover input of the current word is dropped.
            if (bcnt_q == 7'd63) begin
                full_d  = 1'b0;
                state_d = eop_seen_d ? S_FIN : S_DRAIN;
            end
        end

        // A new sop restarts decoding from any state, abandoning the old block silently.
        if (xfer && sop_i) begin
            hold_d     = data_i;
            full_d     = 1'b1;
            ptr_d      = 3'd0;
            eop_seen_d = eop_i;
            bcnt_d     = 7'd0;
            state_d    = S_HDR;
            vld_d      = 1'b0;
            done_d     = 1'b0;
`ifdef AIDC_LITE_DECOMP_ZRLE_ERRCHK_EN
            err_d      = 1'b0;
            fail_d     = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            full_q     <= 1'b0;
            ptr_q      <= 3'd0;
            eop_seen_q <= 1'b0;
            run_q      <= 7'd0;
            bcnt_q     <= 7'd0;
            asm_q      <= '0;
            vld_q      <= 1'b0;
            addr_q     <= 3'd0;
            data_q     <= '0;
            done_q     <= 1'b0;
`ifdef AIDC_LITE_DECOMP_ZRLE_ERRCHK_EN
            err_q      <= 1'b0;
            fail_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            ptr_q      <= ptr_d;
            eop_seen_q <= eop_seen_d;
            run_q      <= run_d;
            bcnt_q     <= bcnt_d;
            asm_q      <= asm_d;
            vld_q      <= vld_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
`ifdef AIDC_LITE_DECOMP_ZRLE_ERRCHK_EN
            err_q      <= err_d;
            fail_q     <= fail_d;
`endif
        end
    end

    assign ready_o = ~full_q;
    assign valid_o = vld_q;
    assign sop_o   = vld_q && (addr_q == 3'd0);
    assign eop_o   = vld_q && (addr_q == 3'd7);
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign done_o  = done_q;
`ifdef AIDC_LITE_DECOMP_ZRLE_ERRCHK_EN
    assign fail_o  = fail_q;
`else
    assign fail_o  = 1'b0;
`endif
endmodule
